// File: rtl/f_pc_npc_pkg.sv
// Shared encodings and address-map constants for the fetch-stage PC block.
package f_pc_npc_pkg;

  typedef enum logic [2:0] {
    NpcPc4    = 3'd0,
    NpcBranch = 3'd1,
    NpcJ      = 3'd2,
    NpcJr     = 3'd3
  } npc_op_e;

  localparam logic [31:0] DefPcReset  = 32'h0000_3000;
  localparam logic [31:0] DefExcEntry = 32'h0000_4180;
  localparam logic [31:0] DefTextLo   = 32'h0000_3000;
  localparam logic [31:0] DefTextHi   = 32'h0000_6FFC;

endpackage

// File: rtl/f_pc_npc_if.sv
// Decode/CP0-to-fetch signal bundle; master drives decode state, slave is the PC block.
interface f_pc_npc_if;
  logic        stall;
  logic [2:0]  npc_op;
  logic        flag;
  logic [31:0] d_pc;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] d_rs;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] f_pc;
  logic        f_bd;
  logic        f_exc_adel;

  modport master (
    output stall, npc_op, flag, d_pc, d_imm16, d_imm26, d_rs, req, eret, epc,
    input  f_pc, f_bd, f_exc_adel
  );

  modport slave (
    input  stall, npc_op, flag, d_pc, d_imm16, d_imm26, d_rs, req, eret, epc,
    output f_pc, f_bd, f_exc_adel
  );
endinterface

// File: rtl/f_pc_npc_npc_calc.sv
// Next-PC and delay-slot marker from the decode-stage select, ignoring exceptions and stall.
module f_pc_npc_npc_calc
  import f_pc_npc_pkg::*;
(
  input  logic [2:0]  npc_op_i,
  input  logic        flag_i,
  input  logic [31:0] f_pc_i,
  input  logic [31:0] d_pc_i,
  input  logic [15:0] d_imm16_i,
  input  logic [25:0] d_imm26_i,
  input  logic [31:0] d_rs_i,
  output logic [31:0] next_pc_o,
  output logic        next_bd_o
);

  logic [31:0] seq_pc;
  logic [31:0] br_target;

  assign seq_pc    = f_pc_i + 32'd4;
  assign br_target = d_pc_i + 32'd4 + {{14{d_imm16_i[15]}}, d_imm16_i, 2'b00};

  always_comb begin
    next_pc_o = seq_pc;
    next_bd_o = 1'b0;
    case (npc_op_i)
      NpcBranch: begin
        next_pc_o = flag_i ? br_target : seq_pc;
        next_bd_o = 1'b1;
      end
      NpcJ: begin
        next_pc_o = {d_pc_i[31:28], d_imm26_i, 2'b00};
        next_bd_o = 1'b1;
      end
      NpcJr: begin
        // Misaligned targets pass through; the AdEL check reports them.
        next_pc_o = d_rs_i;
        next_bd_o = 1'b1;
      end
      default: begin
        next_pc_o = seq_pc;
        next_bd_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/f_pc_npc.sv
// Fetch-stage PC register with exception/eret/stall priority and fetch address-error check.
module f_pc_npc
  import f_pc_npc_pkg::*;
#(
  parameter logic [31:0] PcReset  = DefPcReset,
  parameter logic [31:0] ExcEntry = DefExcEntry,
  parameter logic [31:0] TextLo   = DefTextLo,
  parameter logic [31:0] TextHi   = DefTextHi
) (
  input  logic         clk,
  input  logic         reset_n,
  f_pc_npc_if.slave    bus
);

  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic [31:0] calc_pc;
  logic        calc_bd;

  f_pc_npc_npc_calc u_npc_calc (
    .npc_op_i  (bus.npc_op),
    .flag_i    (bus.flag),
    .f_pc_i    (pc_q),
    .d_pc_i    (bus.d_pc),
    .d_imm16_i (bus.d_imm16),
    .d_imm26_i (bus.d_imm26),
    .d_rs_i    (bus.d_rs),
    .next_pc_o (calc_pc),
    .next_bd_o (calc_bd)
  );

  // Req and eret redirect even while the hazard unit is freezing fetch.
  always_comb begin
    pc_d = pc_q;
    bd_d = bd_q;
    if (bus.req) begin
      pc_d = ExcEntry;
      bd_d = 1'b0;
    end else if (bus.eret) begin
      pc_d = bus.epc;
      bd_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d = calc_pc;
      bd_d = calc_bd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q <= PcReset;
      bd_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      bd_q <= bd_d;
    end
  end

  assign bus.f_pc       = pc_q;
  assign bus.f_bd       = bd_q;
  assign bus.f_exc_adel = (pc_q[1:0] != 2'b00) || (pc_q < TextLo) || (pc_q > TextHi);

endmodule

// File: tb/tb_f_pc_npc.sv
// Directed vector table plus randomized run against an arithmetic reference model.
module tb_f_pc_npc;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  f_pc_npc_if bus ();

  f_pc_npc dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    bit          req;
    bit          eret;
    bit          stall;
    logic [2:0]  op;
    bit          flag;
    logic [31:0] d_pc;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] d_rs;
    logic [31:0] epc;
    logic [31:0] exp_pc;
    bit          exp_bd;
    bit          exp_adel;
  } vec_t;

  vec_t vecs[23];

  logic [31:0] m_pc;
  bit          m_bd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset_n     = v.rst_n;
    bus.req     = v.req;
    bus.eret    = v.eret;
    bus.stall   = v.stall;
    bus.npc_op  = v.op;
    bus.flag    = v.flag;
    bus.d_pc    = v.d_pc;
    bus.d_imm16 = v.imm16;
    bus.d_imm26 = v.imm26;
    bus.d_rs    = v.d_rs;
    bus.epc     = v.epc;
  endtask

  function automatic bit legal(input logic [31:0] pc);
    return (pc % 4 == 0) && (pc >= 32'h3000) && (pc <= 32'h6FFC);
  endfunction

  // Reference: apply the priority rules to the model state using plain arithmetic.
  task automatic model_step(input vec_t v);
    int          off;
    logic [31:0] nxt;
    bit          nbd;
    nxt = m_pc;
    nbd = m_bd;
    if (!v.rst_n) begin
      nxt = 32'h3000; nbd = 0;
    end else if (v.req) begin
      nxt = 32'h4180; nbd = 0;
    end else if (v.eret) begin
      nxt = v.epc; nbd = 0;
    end else if (!v.stall) begin
      if (v.op == 3'd1) begin
        off = int'($signed(v.imm16)) * 4;
        nxt = v.flag ? v.d_pc + 32'd4 + 32'(off) : m_pc + 32'd4;
        nbd = 1;
      end else if (v.op == 3'd2) begin
        nxt = (v.d_pc / 32'h1000_0000) * 32'h1000_0000 + 32'(v.imm26) * 32'd4;
        nbd = 1;
      end else if (v.op == 3'd3) begin
        nxt = v.d_rs; nbd = 1;
      end else begin
        nxt = m_pc + 32'd4; nbd = 0;
      end
    end
    m_pc = nxt;
    m_bd = nbd;
  endtask

  function automatic vec_t mk(input bit rst_n, req, eret, stall, input logic [2:0] op,
                              input bit flag, input logic [31:0] d_pc, input logic [15:0] imm16,
                              input logic [25:0] imm26, input logic [31:0] d_rs, epc, exp_pc,
                              input bit exp_bd, exp_adel);
    vec_t v;
    v = '{rst_n, req, eret, stall, op, flag, d_pc, imm16, imm26, d_rs, epc, exp_pc, exp_bd,
          exp_adel};
    return v;
  endfunction

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;

    //            rst req ert stl op flg d_pc      imm16     imm26       d_rs       epc
    vecs[0]  = mk(0, 0, 0, 0, 3'd0, 0, 32'h0,    16'h0,    26'h0,     32'h0,     32'h0,
                  32'h3000, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 3'd0, 0, 32'h0,    16'h0,    26'h0,     32'h0,     32'h0,
                  32'h3004, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 3'd0, 0, 32'h0,    16'h0,    26'h0,     32'h0,     32'h0,
                  32'h3008, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 3'd1, 1, 32'h3004, 16'hFFFE, 26'h0,     32'h0,     32'h0,
                  32'h3000, 1, 0);
    vecs[4]  = mk(1, 0, 0, 0, 3'd0, 0, 32'h0,    16'h0,    26'h0,     32'h0,     32'h0,
                  32'h3004, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 3'd0, 0, 32'h0,    16'h0,    26'h0,     32'h0,     32'h0,
                  32'h3008, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 3'd1, 0, 32'h3004, 16'hFFFE, 26'h0,     32'h0,     32'h0,
                  32'h300C, 1, 0);
    vecs[7]  = mk(1, 0, 0, 0, 3'd2, 0, 32'h3010, 16'h0,    26'h0C40,  32'h0,     32'h0,
                  32'h3100, 1, 0);
    vecs[8]  = mk(1, 0, 0, 0, 3'd3, 0, 32'h0,    16'h0,    26'h0,     32'h3202,  32'h0,
                  32'h3202, 1, 1);
    vecs[9]  = mk(1, 0, 0, 1, 3'd1, 1, 32'h3004, 16'hFFFE, 26'h0,     32'h0,     32'h0,
                  32'h3202, 1, 1);
    vecs[10] = mk(1, 0, 0, 1, 3'd1, 1, 32'h3004, 16'hFFFE, 26'h0,     32'h0,     32'h0,
                  32'h3202, 1, 1);
    vecs[11] = mk(1, 0, 0, 1, 3'd1, 1, 32'h3004, 16'hFFFE, 26'h0,     32'h0,     32'h0,
                  32'h3202, 1, 1);
    vecs[12] = mk(1, 0, 0, 0, 3'd1, 1, 32'h3004, 16'hFFFE, 26'h0,     32'h0,     32'h0,
                  32'h3000, 1, 0);
    vecs[13] = mk(1, 1, 1, 1, 3'd1, 1, 32'h3004, 16'h0010, 26'h0,     32'h0,     32'h3024,
                  32'h4180, 0, 0);
    vecs[14] = mk(1, 0, 1, 0, 3'd1, 1, 32'h3004, 16'h0010, 26'h0,     32'h0,     32'h3024,
                  32'h3024, 0, 0);
    vecs[15] = mk(1, 0, 0, 0, 3'd3, 0, 32'h0,    16'h0,    26'h0,     32'h7000,  32'h0,
                  32'h7000, 1, 1);
    vecs[16] = mk(1, 0, 0, 0, 3'd3, 0, 32'h0,    16'h0,    26'h0,     32'h6FFC,  32'h0,
                  32'h6FFC, 1, 0);
    vecs[17] = mk(1, 0, 0, 0, 3'd3, 0, 32'h0,    16'h0,    26'h0,     32'h2FFC,  32'h0,
                  32'h2FFC, 1, 1);
    vecs[18] = mk(1, 0, 0, 0, 3'd3, 0, 32'h0,    16'h0,    26'h0,     32'hFFFFFFFC, 32'h0,
                  32'hFFFFFFFC, 1, 1);
    vecs[19] = mk(1, 0, 0, 0, 3'd0, 0, 32'h0,    16'h0,    26'h0,     32'h0,     32'h0,
                  32'h0, 0, 1);
    vecs[20] = mk(1, 0, 0, 0, 3'd5, 1, 32'h3004, 16'h0,    26'h0,     32'h0,     32'h0,
                  32'h4, 0, 1);
    vecs[21] = mk(0, 1, 1, 1, 3'd3, 0, 32'h0,    16'h0,    26'h0,     32'h5000,  32'h5000,
                  32'h3000, 0, 0);
    vecs[22] = mk(1, 0, 0, 0, 3'd3, 0, 32'h0,    16'h0,    26'h0,     32'h3001,  32'h0,
                  32'h3001, 1, 1);

    drive(vecs[0]);
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d f_pc", i), bus.f_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d f_bd", i), 32'(bus.f_bd), 32'(vecs[i].exp_bd));
      chk($sformatf("vec%0d adel", i), 32'(bus.f_exc_adel), 32'(vecs[i].exp_adel));
    end

    // Randomized run; the first cycle forces reset to seed the model state.
    m_pc = 32'h0;
    m_bd = 0;
    for (int i = 0; i < 400; i++) begin
      v.rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 99) >= 3);
      v.req   = ($urandom_range(0, 99) < 5);
      v.eret  = ($urandom_range(0, 99) < 6);
      v.stall = ($urandom_range(0, 99) < 20);
      v.op    = 3'($urandom_range(0, 7));
      v.flag  = 1'($urandom);
      v.d_pc  = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 'hFFF)) * 4;
      v.imm16 = 16'($urandom);
      v.imm26 = 26'($urandom);
      v.d_rs  = ($urandom_range(0, 3) == 0) ? $urandom : 32'h2FF0 + 32'($urandom_range(0, 'h1010)) * 4;
      v.epc   = 32'h3000 + 32'($urandom_range(0, 'hFFF)) * 4;
      drive(v);
      model_step(v);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d f_pc", i), bus.f_pc, m_pc);
      chk($sformatf("rnd%0d f_bd", i), 32'(bus.f_bd), 32'(m_bd));
      chk($sformatf("rnd%0d adel", i), 32'(bus.f_exc_adel), 32'(!legal(m_pc)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
